// File: rtl/control_comparador_serial_pkg.sv
// Shared codes for the bit-serial comparator: PQ cell encoding, FSM states
// and the one-hot decode of a final PQ pair into result flags.
package control_comparador_serial_pkg;

   localparam logic [1:0] PQ_IGUAL  = 2'b01;
   localparam logic [1:0] PQ_MAYOR  = 2'b10;
   localparam logic [1:0] PQ_MENOR  = 2'b00;
   localparam logic [1:0] PQ_ILEGAL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPARE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   typedef struct packed {
      logic mayor;
      logic menor;
      logic igual;
      logic error;
   } flags_t;

   function automatic flags_t decode_pq(input logic [1:0] pq);
      flags_t f;
      f = '0;
      case (pq)
         PQ_MAYOR:  f.mayor = 1'b1;
         PQ_MENOR:  f.menor = 1'b1;
         PQ_IGUAL:  f.igual = 1'b1;
         PQ_ILEGAL: f.error = 1'b1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/celdaTipica.sv
// Typical comparator cell: next P,Q from present p,q and one bit pair.
// 01 resolves on the first differing bit; 10 and 00 are absorbing; 11 stays 11.
module celdaTipica (
   input  logic p,
   input  logic q,
   input  logic Ai,
   input  logic Bi,
   output logic P,
   output logic Q
);

   assign P = p | (q & Ai & ~Bi);
   assign Q = q & (p | ~(Ai ^ Bi));

endmodule

// File: rtl/control_comparador_serial.sv
// Bit-serial magnitude comparator: one celdaTipica walks the operands MSB first,
// stops as soon as the result is decided and reports it with a done pulse.
module control_comparador_serial
   import control_comparador_serial_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic         mayor,
   output logic         menor,
   output logic         igual,
   output logic         error
);

   localparam int IDX_W = $clog2(N);
   localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(N - 1);

   state_t           state_q;
   logic [N-1:0]     a_q, b_q;
   logic [1:0]       pq_q;
   logic [1:0]       pq_d;
   logic [IDX_W-1:0] idx_q;
   logic             armed_q;

   celdaTipica u_celda (
      .p  (pq_q[1]),
      .q  (pq_q[0]),
      .Ai (a_q[idx_q]),
      .Bi (b_q[idx_q]),
      .P  (pq_d[1]),
      .Q  (pq_d[0])
   );

   // NOTE: all state uses non-blocking assignments so every flop samples the
   // pre-edge values; blocking here would let idx/pq updates race the cell.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: operand registers are reset too; they are few bits and a
         // defined value keeps the cell inputs free of X after reset.
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         pq_q    <= PQ_IGUAL;
         idx_q   <= '0;
         armed_q <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         mayor   <= 1'b0;
         menor   <= 1'b0;
         igual   <= 1'b0;
         error   <= 1'b0;
      end else begin
         // armed_q masks the first edge after reset release, so a start
         // present while reset deasserts is never taken.
         armed_q <= 1'b1;
         done    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && armed_q) begin
                  a_q     <= a;
                  b_q     <= b;
                  pq_q    <= PQ_IGUAL;
                  idx_q   <= IDX_MSB;
                  busy    <= 1'b1;
                  state_q <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               pq_q <= pq_d;
               if (pq_d != PQ_IGUAL || idx_q == '0) begin
                  {mayor, menor, igual, error} <= decode_pq(pq_d);
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  idx_q <= idx_q - 1'b1;
               end
            end
            S_DONE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  pq_q    <= PQ_IGUAL;
                  idx_q   <= IDX_MSB;
                  busy    <= 1'b1;
                  state_q <= S_COMPARE;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_control_comparador_serial.sv
// Scoreboard bench for control_comparador_serial (N=8): directed vectors push
// expected flags and done cycle; a negedge monitor pops on every done pulse.
module tb_control_comparador_serial;

   localparam int N = 8;
   localparam logic [3:0] F_MAYOR = 4'b1000;
   localparam logic [3:0] F_MENOR = 4'b0100;
   localparam logic [3:0] F_IGUAL = 4'b0010;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [N-1:0] a, b;
   logic         busy, done, mayor, menor, igual, error;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      string      name;
      logic [3:0] flags;
      int         at_cyc;
   } exp_t;

   exp_t sb[$];

   control_comparador_serial #(.N(N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .mayor   (mayor),
      .menor   (menor),
      .igual   (igual),
      .error   (error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check({e.name, "_flags"}, {28'd0, mayor, menor, igual, error}, {28'd0, e.flags});
            check({e.name, "_done_cycle"}, cyc, e.at_cyc);
         end
      end
   end

   // Issue one comparison and follow busy through to the cycle after done.
   task automatic issue(input string name, input logic [7:0] va, input logic [7:0] vb,
                        input logic [3:0] fl, input int lat);
      int acc;
      exp_t e;
      start = 1'b1; a = va; b = vb;
      @(posedge clk); #1;
      acc = cyc;
      start = 1'b0;
      e.name = name; e.flags = fl; e.at_cyc = acc + lat;
      sb.push_back(e);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         check({name, "_busy"}, busy, 1'b1);
      end
      @(negedge clk);
      check({name, "_busy_in_done"}, busy, 1'b0);
      @(negedge clk);
      check({name, "_done_single"}, done, 1'b0);
      check({name, "_flags_hold"}, {mayor, menor, igual, error}, fl);
   endtask

   initial begin
      int   acc;
      exp_t e;
      reset_n = 1'b0; start = 1'b0; a = '0; b = '0;
      #12;
      check("reset_outputs", {busy, done, mayor, menor, igual, error}, 6'd0);

      // start present while reset releases must be dropped
      @(negedge clk);
      reset_n = 1'b1; start = 1'b1; a = 8'h80; b = 8'h00;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("start_at_release_ignored", busy, 1'b0);
      repeat (2) @(negedge clk);

      issue("eq_a5", 8'hA5, 8'hA5, F_IGUAL, 8);
      issue("msb_80_7f", 8'h80, 8'h7F, F_MAYOR, 1);
      issue("lsb_00_01", 8'h00, 8'h01, F_MENOR, 8);

      // start pulsed while busy: ignored, operands not recaptured
      @(negedge clk);
      start = 1'b1; a = 8'h10; b = 8'h20;
      @(posedge clk); #1;
      acc = cyc;
      start = 1'b0;
      e.name = "busy_start"; e.flags = F_MENOR; e.at_cyc = acc + 3;
      sb.push_back(e);
      repeat (3) @(negedge clk);
      start = 1'b1; a = 8'hFF; b = 8'h00;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("busy_start_no_recapture", busy, 1'b0);

      // reset in cycle 3 of an equal-word compare
      @(negedge clk);
      start = 1'b1; a = 8'h3C; b = 8'h3C;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      check("abort_outputs_clear", {busy, done, mayor, menor, igual, error}, 6'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_stays_idle", busy, 1'b0);
      issue("after_abort_81_80", 8'h81, 8'h80, F_MAYOR, 8);

      // back-to-back: start held through DONE, second pair loaded without IDLE
      @(negedge clk);
      start = 1'b1; a = 8'hF0; b = 8'hE0;
      @(posedge clk); #1;
      acc = cyc;
      e.name = "b2b_first"; e.flags = F_MAYOR; e.at_cyc = acc + 4;
      sb.push_back(e);
      e.name = "b2b_second"; e.flags = F_MAYOR; e.at_cyc = acc + 12;
      sb.push_back(e);
      a = 8'h02; b = 8'h01;
      repeat (5) @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("b2b_no_idle_gap", busy, 1'b1);

      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion before 100000");
      $fatal(1, "watchdog");
   end

endmodule
